adder_arbiter: RTL and testbench
================================

# adder_arbiter

Time-shares one 4-bit ripple-carry adder between two independent requesters. Each requester presents an operand pair plus carry-in through a valid/ready handshake. A round-robin arbiter grants one requester at a time. The granted operands are registered, summed, and the 5-bit result is returned with a valid/ready handshake tagged with the requester ID. The block sits between the switch/UART-driven request sources and the shared adder datapath.

## Interface
Parameters:
- WIDTH, 4, operand width; the result is WIDTH+1 bits (carry-out in MSB).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req0_valid  in  1  requester 0 has an operation.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_cin  in  1  requester 0 carry-in.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req1_valid, req1_a, req1_b, req1_cin, req1_ready  same as requester 0, for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_sum  out  WIDTH+1  {carry-out, sum}.
- rsp_id  out  1  requester that owns rsp_sum.
- busy  out  1  high whenever state is not IDLE.
- Only with ADDER_ARB_STATS_EN: grant_cnt0, grant_cnt1  out  8  saturating grant counters.

## Operation
- FSM states are IDLE, EXEC and RESP.
- **IDLE:**
  - If any reqN_valid is high, the grant is chosen; reqN_ready=1 for the granted requester only, in the same cycle (combinational).
  - a, b and cin are captured into operand registers, the grant is captured into id_q, and the FSM moves to EXEC.
  - If no requester is valid, the FSM stays in IDLE.
- **Arbitration:**
  - If only one requester is valid, it wins.
  - If both are valid, the requester not equal to last_grant wins. last_grant updates on each acceptance.
- **EXEC:**
  - The registered operands drive the adder instance.
  - The adder output {cout, sum} is registered into rsp_sum.
  - Unconditional move to RESP.
- **RESP:**
  - rsp_valid=1. rsp_sum and rsp_id are held stable.
  - On rsp_ready=1, the FSM moves to IDLE.
  - rsp_valid drops in the following cycle.
  - No new request is accepted in the cycle the response is consumed.
- **Arithmetic:** rsp_sum = a + b + cin, unsigned, WIDTH+1 bits, with no overflow loss. Maximum is 15+15+1 = 31 = 5'b11111.
- Requests are never dropped. An unaccepted requester must hold valid and its operands; the block does not require this, but it never samples them until grant.
- **Reset mid-operation:** the in-flight operation is discarded and no response is produced. The FSM returns to IDLE.
- **Reset values:**
  - state=IDLE, last_grant=1 (requester 0 wins the first tie).
  - rsp_valid=0, rsp_sum=0, rsp_id=0, busy=0, req0_ready=req1_ready=0.
  - Counters=0.

## Timing
- Acceptance in cycle N gives rsp_valid=1 in cycle N+2.
- The response is held until rsp_ready is sampled high.
- Minimum issue interval is 3 cycles (accept, EXEC, RESP with rsp_ready=1).
- reqN_ready depends combinationally on reqN_valid of both requesters and on state. There are no other combinational input-to-output paths.
- rsp_* and busy are driven directly from registers.

## Configuration
- Macro ADDER_ARB_STATS_EN.
- **Defined:**
  - grant_cnt0 and grant_cnt1 exist.
  - Each increments by 1 on its requester's acceptance and saturates at 255.
  - Both are cleared by rst.
- **Undefined:** the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Package adder_arb_pkg holds:
  - the WIDTH default constant;
  - the state enum (IDLE, EXEC, RESP);
  - the req_id_t typedef (1 bit);
  - the sum_t typedef (WIDTH+1 bits).
- One sub-module, ripple_adder: a parameterised WIDTH-bit ripple chain of full adders with inputs a, b, cin and outputs sum and cout. It is instantiated once.

## Test plan
- **Single request:** req0 with a=5, b=9, cin=1 gives req0_ready in cycle 0, then rsp_valid at cycle 2 with rsp_sum=5'd15 and rsp_id=0.
- **Overflow:** req1 with a=15, b=15, cin=1 gives rsp_sum=5'b11111 and rsp_id=1.
- **Tie fairness:** both valid continuously from reset, with rsp_ready=1, give grant order 0,1,0,1. Each result matches its own operands.
- **Backpressure:** rsp_ready=0 for 5 cycles holds rsp_valid, rsp_sum and rsp_id stable and keeps both readies at 0. Consumption then returns the FSM to IDLE.
- **Reset mid-operation:** rst asserted in EXEC gives rsp_valid=0 and busy=0 immediately, and no response afterwards. The next tie grants requester 0.
- **With ADDER_ARB_STATS_EN:** 300 req0-only acceptances give grant_cnt0=255 and grant_cnt1=0.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// Shared types and the round-robin grant rule for the time-shared adder arbiter.
// Used by adder_arbiter, whose ADDER_ARB_STATS_EN build option adds grant counters.
package adder_arb_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic req_id_t;

    typedef logic [WIDTH_DEF:0] sum_t;

    // On a tie the requester that did not win last time is served.
    function automatic req_id_t pick_grant(input logic v0, input logic v1, input req_id_t last);
        if (v0 && v1) begin
            return ~last;
        end else if (v1) begin
            return 1'b1;
        end else begin
            return 1'b0;
        end
    endfunction

endpackage

// File: rtl/adder_arbiter_ripple_adder.sv
// Parameterised ripple-carry adder built from a chain of full adders.
module ripple_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_fa
            assign sum[i]       = a[i] ^ b[i] ^ carry[i];
            assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign cout = carry[WIDTH];

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter time-sharing one ripple adder between two requesters.
// Define ADDER_ARB_STATS_EN to add saturating per-requester grant counters.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             req1_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH:0]   rsp_sum,
    output logic             rsp_id,
    output logic             busy
`ifdef ADDER_ARB_STATS_EN
    ,
    output logic [7:0]       grant_cnt0,
    output logic [7:0]       grant_cnt1
`endif
);

    state_t           state;
    req_id_t          last_grant;
    req_id_t          grant;
    req_id_t          id_q;
    logic             accept;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             cin_q;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic [WIDTH:0]   sum_q;
    logic             valid_q;
    logic             busy_q;

    // Readies are the only combinational outputs; a request is taken only in IDLE.
    always_comb begin
        grant      = pick_grant(req0_valid, req1_valid, last_grant);
        accept     = (state == IDLE) && (req0_valid || req1_valid);
        req0_ready = accept && (grant == 1'b0);
        req1_ready = accept && (grant == 1'b1);
    end

    ripple_adder #(
        .WIDTH(WIDTH)
    ) u_adder (
        .a   (a_q),
        .b   (b_q),
        .cin (cin_q),
        .sum (add_sum),
        .cout(add_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            id_q       <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            sum_q      <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q        <= grant ? req1_a : req0_a;
                        b_q        <= grant ? req1_b : req0_b;
                        cin_q      <= grant ? req1_cin : req0_cin;
                        id_q       <= grant;
                        last_grant <= grant;
                        busy_q     <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    sum_q   <= {add_cout, add_sum};
                    valid_q <= 1'b1;
                    state   <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // id_q is only rewritten on acceptance, so it stays stable through RESP.
    assign rsp_valid = valid_q;
    assign rsp_sum   = sum_q;
    assign rsp_id    = id_q;
    assign busy      = busy_q;

`ifdef ADDER_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (req0_ready && (grant_cnt0 != 8'hFF)) begin
                grant_cnt0 <= grant_cnt0 + 8'd1;
            end
            if (req1_ready && (grant_cnt1 != 8'hFF)) begin
                grant_cnt1 <= grant_cnt1 + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed scoreboard bench for adder_arbiter; also exercises ADDER_ARB_STATS_EN when defined.
module tb_adder_arbiter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_cin;
    logic         req0_ready;
    logic         req1_valid;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_cin;
    logic         req1_ready;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W:0]   rsp_sum;
    logic         rsp_id;
    logic         busy;
`ifdef ADDER_ARB_STATS_EN
    logic [7:0]   grant_cnt0;
    logic [7:0]   grant_cnt1;
`endif

    adder_arbiter #(
        .WIDTH(W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0_valid(req0_valid),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req0_cin  (req0_cin),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .req1_cin  (req1_cin),
        .req1_ready(req1_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .busy      (busy)
`ifdef ADDER_ARB_STATS_EN
        ,
        .grant_cnt0(grant_cnt0),
        .grant_cnt1(grant_cnt1)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       id;
        logic [W:0] sum;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    endfunction

    task automatic push_exp(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        exp_t e;
        e.id  = id;
        e.sum = ref_sum(a, b, cin);
        sb.push_back(e);
    endtask

    // A response is consumed on the edge after it is seen with rsp_ready high.
    task automatic check_output();
        exp_t e;
        if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check_val("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                check_val("rsp_sum", {27'd0, rsp_sum}, {27'd0, e.sum});
                check_val("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_output();
    endtask

    task automatic apply_stimulus(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        if (id == 1'b0) begin
            req0_valid = 1'b1;
            req0_a     = a;
            req0_b     = b;
            req0_cin   = cin;
        end else begin
            req1_valid = 1'b1;
            req1_a     = a;
            req1_b     = b;
            req1_cin   = cin;
        end
    endtask

    task automatic issue(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         output int waited);
        waited = -1;
        apply_stimulus(id, a, b, cin);
        for (int n = 0; n < 20; n++) begin
            #1;
            if ((id == 1'b0 && req0_ready === 1'b1) || (id == 1'b1 && req1_ready === 1'b1)) begin
                push_exp(id, a, b, cin);
                waited = n;
                tick();
                break;
            end
            tick();
        end
        if (id == 1'b0) req0_valid = 1'b0;
        else            req1_valid = 1'b0;
        if (waited < 0) check_val("accept_timeout", 32'(waited), 32'd0);
    endtask

    task automatic drain(input int budget);
        for (int n = 0; n < budget; n++) begin
            if (sb.size() == 0) break;
            tick();
        end
        check_val("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst        = 1'b1;
        sb.delete();
        tick();
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         w;
        int         idx;
        int         g;
        int         grant_log[4];
        int         exp_order[4];
        logic [W-1:0] a0, b0, a1, b1;
        logic         c0, c1;

        rst        = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_a     = '0;
        req0_b     = '0;
        req0_cin   = 1'b0;
        req1_a     = '0;
        req1_b     = '0;
        req1_cin   = 1'b0;
        rsp_ready  = 1'b1;

        // Reset values
        #2;
        check_val("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_val("reset_rsp_sum", {27'd0, rsp_sum}, 32'd0);
        check_val("reset_rsp_id", {31'd0, rsp_id}, 32'd0);
        check_val("reset_busy", {31'd0, busy}, 32'd0);
        check_val("reset_req0_ready", {31'd0, req0_ready}, 32'd0);
        check_val("reset_req1_ready", {31'd0, req1_ready}, 32'd0);
`ifdef ADDER_ARB_STATS_EN
        check_val("reset_cnt0", {24'd0, grant_cnt0}, 32'd0);
        check_val("reset_cnt1", {24'd0, grant_cnt1}, 32'd0);
`endif
        tick();
        #2;
        rst = 1'b0;

        // Single request: accepted in cycle 0, result visible in cycle 2
        issue(1'b0, 4'd5, 4'd9, 1'b1, w);
        check_val("single_ready_cycle", 32'(w), 32'd0);
        check_val("single_exec_valid", {31'd0, rsp_valid}, 32'd0);
        check_val("single_exec_busy", {31'd0, busy}, 32'd1);
        tick();
        check_val("single_latency_valid", {31'd0, rsp_valid}, 32'd1);
        check_val("single_resp_busy", {31'd0, busy}, 32'd1);
        check_val("single_sum", {27'd0, rsp_sum}, 32'd15);
        check_val("single_id", {31'd0, rsp_id}, 32'd0);
        tick();
        check_val("single_done_valid", {31'd0, rsp_valid}, 32'd0);
        check_val("single_done_busy", {31'd0, busy}, 32'd0);

        // Overflow on requester 1
        issue(1'b1, 4'd15, 4'd15, 1'b1, w);
        tick();
        check_val("ovf_sum", {27'd0, rsp_sum}, 32'd31);
        check_val("ovf_id", {31'd0, rsp_id}, 32'd1);
        drain(5);
        tick();

        // Backpressure holds the response and blocks both requesters
        rsp_ready = 1'b0;
        issue(1'b0, 4'd3, 4'd4, 1'b0, w);
        tick();
        apply_stimulus(1'b0, 4'd6, 4'd6, 1'b0);
        apply_stimulus(1'b1, 4'd2, 4'd2, 1'b0);
        for (int n = 0; n < 5; n++) begin
            #1;
            check_val("bp_valid", {31'd0, rsp_valid}, 32'd1);
            check_val("bp_sum", {27'd0, rsp_sum}, 32'd7);
            check_val("bp_id", {31'd0, rsp_id}, 32'd0);
            check_val("bp_req0_ready", {31'd0, req0_ready}, 32'd0);
            check_val("bp_req1_ready", {31'd0, req1_ready}, 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check_val("consume_req0_ready", {31'd0, req0_ready}, 32'd0);
        check_val("consume_req1_ready", {31'd0, req1_ready}, 32'd0);
        check_output();
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check_val("bp_after_valid", {31'd0, rsp_valid}, 32'd0);
        check_val("bp_after_busy", {31'd0, busy}, 32'd0);
        check_val("bp_scoreboard", 32'(sb.size()), 32'd0);
        tick();

        // Reset during EXEC discards the operation
        issue(1'b1, 4'd1, 4'd1, 1'b0, w);
        check_val("rst_pre_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check_val("rst_mid_valid", {31'd0, rsp_valid}, 32'd0);
        check_val("rst_mid_busy", {31'd0, busy}, 32'd0);
        sb.delete();
        tick();
        #2;
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            tick();
            check_val("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        apply_stimulus(1'b0, 4'd2, 4'd3, 1'b0);
        apply_stimulus(1'b1, 4'd4, 4'd4, 1'b1);
        #1;
        check_val("rst_tie_req0_ready", {31'd0, req0_ready}, 32'd1);
        check_val("rst_tie_req1_ready", {31'd0, req1_ready}, 32'd0);
        push_exp(1'b0, 4'd2, 4'd3, 1'b0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain(10);

        // Tie fairness from reset: grants alternate 0,1,0,1
        reset_dut();
        a0 = 4'd1; b0 = 4'd2; c0 = 1'b0;
        a1 = 4'd7; b1 = 4'd8; c1 = 1'b1;
        apply_stimulus(1'b0, a0, b0, c0);
        apply_stimulus(1'b1, a1, b1, c1);
        exp_order = '{0, 1, 0, 1};
        grant_log = '{2, 2, 2, 2};
        idx = 0;
        for (int n = 0; n < 40 && idx < 4; n++) begin
            #1;
            g = -1;
            if (req0_ready === 1'b1 && req1_ready === 1'b1)
                check_val("one_hot_ready", {31'd0, req1_ready}, 32'd0);
            if (req0_ready === 1'b1) begin
                push_exp(1'b0, a0, b0, c0);
                g = 0;
            end else if (req1_ready === 1'b1) begin
                push_exp(1'b1, a1, b1, c1);
                g = 1;
            end
            tick();
            if (g == 0) begin
                grant_log[idx] = 0;
                idx++;
                a0 = a0 + 4'd5; b0 = b0 + 4'd3; c0 = ~c0;
                apply_stimulus(1'b0, a0, b0, c0);
            end else if (g == 1) begin
                grant_log[idx] = 1;
                idx++;
                a1 = a1 + 4'd6; b1 = b1 + 4'd9; c1 = ~c1;
                apply_stimulus(1'b1, a1, b1, c1);
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("tie_grant_%0d", i), 32'(grant_log[i]), 32'(exp_order[i]));
        end
        drain(10);

`ifdef ADDER_ARB_STATS_EN
        // Counter saturation
        reset_dut();
        check_val("stats_cnt0_cleared", {24'd0, grant_cnt0}, 32'd0);
        for (int i = 0; i < 300; i++) begin
            issue(1'b0, i[3:0], i[7:4], i[0], w);
            drain(10);
        end
        check_val("stats_cnt0", {24'd0, grant_cnt0}, 32'd255);
        check_val("stats_cnt1", {24'd0, grant_cnt1}, 32'd0);
`endif

        check_val("final_scoreboard", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
